// File: rtl/wieg_pkg.sv
// wieg_pkg: state encoding and default thresholds shared by the cradle controller.
package wieg_pkg;
  typedef enum logic [2:0] {RUST, OPSTART, WIEGEN, AFBOUW, FOUT} state_t;
  localparam int N_GELIJK_DEF = 4;
  localparam int N_DAAL_DEF = 2;
  localparam int N_AFBOUW_DEF = 8;
  localparam int N_ERR_DEF = 3;
endpackage

// File: rtl/wieg_teller.sv
// wieg_teller: saturating event counter; last flags the increment that reaches N.
module wieg_teller #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);
  localparam int W = $clog2(N + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != W'(N)) ? cnt_q + 1'b1 : cnt_q;
  assign last = inc && cnt_q >= W'(N - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wieg_sturing.sv
// wieg_sturing: cradle rocking controller driven by stress-trend strobes.
module wieg_sturing
  import wieg_pkg::*;
#(
  parameter int N_GELIJK = N_GELIJK_DEF,
  parameter int N_DAAL = N_DAAL_DEF,
  parameter int N_AFBOUW = N_AFBOUW_DEF,
  parameter int N_ERR = N_ERR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk4,
  input  logic       start,
  input  logic       gedaald,
  input  logic       gelijk,
  input  logic       error,
  output logic [1:0] stand,
  output logic       motor_aan,
  output logic       klaar,
  output logic       fout
);
  state_t     state_q;
  logic [1:0] stand_q;
  logic       motor_q, klaar_q, fout_q;
  logic       in_w, in_a, e, d, g, r;
  logic       err_last, daal_last, gel_last, afb_last;
  // Strobe decode with priority error > gedaald > gelijk > rose.
  assign in_w = state_q == WIEGEN;
  assign in_a = state_q == AFBOUW;
  assign e = clk4 && error;
  assign d = clk4 && !error && gedaald;
  assign g = clk4 && !error && !gedaald && gelijk;
  assign r = clk4 && !error && !gedaald && !gelijk;
  wieg_teller #(.N(N_ERR)) u_err (
    .clk(clk), .reset(reset), .clr(!(in_w || in_a) || (clk4 && !error)),
    .inc((in_w || in_a) && e), .last(err_last)
  );
  wieg_teller #(.N(N_DAAL)) u_daal (
    .clk(clk), .reset(reset), .clr(!in_w || g || r || daal_last),
    .inc(in_w && d), .last(daal_last)
  );
  wieg_teller #(.N(N_GELIJK)) u_gelijk (
    .clk(clk), .reset(reset), .clr(!in_w || d || r || gel_last),
    .inc(in_w && g), .last(gel_last)
  );
  wieg_teller #(.N(N_AFBOUW)) u_afbouw (
    .clk(clk), .reset(reset), .clr(!in_a || afb_last),
    .inc(in_a && (d || g)), .last(afb_last)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUST;
      stand_q <= 2'd0;
      motor_q <= 1'b0;
      klaar_q <= 1'b0;
      fout_q  <= 1'b0;
    end else begin
      klaar_q <= 1'b0;
      case (state_q)
        RUST: if (start) begin
          state_q <= OPSTART;
          stand_q <= 2'd2;
          motor_q <= 1'b1;
        end
        OPSTART: if (clk4) state_q <= WIEGEN;
        WIEGEN: begin
          if (err_last) begin
            state_q <= FOUT;
            stand_q <= 2'd0;
            motor_q <= 1'b0;
            fout_q  <= 1'b1;
          end else if (daal_last) begin
            if (stand_q > 2'd1) stand_q <= stand_q - 2'd1;
            else state_q <= AFBOUW;
          end else if (gel_last) stand_q <= (stand_q == 2'd3) ? 2'd3 : stand_q + 2'd1;
          else if (r) stand_q <= 2'd3;
        end
        AFBOUW: begin
          if (err_last) begin
            state_q <= FOUT;
            stand_q <= 2'd0;
            motor_q <= 1'b0;
            fout_q  <= 1'b1;
          end else if (afb_last) begin
            state_q <= RUST;
            stand_q <= 2'd0;
            motor_q <= 1'b0;
            klaar_q <= 1'b1;
          end else if (r) begin
            state_q <= WIEGEN;
            stand_q <= 2'd2;
          end
        end
        FOUT: if (start) begin
          state_q <= RUST;
          fout_q  <= 1'b0;
        end
        default: state_q <= RUST;
      endcase
    end
  end
  assign stand = stand_q;
  assign motor_aan = motor_q;
  assign klaar = klaar_q;
  assign fout = fout_q;
endmodule

// File: tb/tb_wieg_sturing.sv
// tb_wieg_sturing: directed scoreboard bench for the cradle controller.
module tb_wieg_sturing;
  logic       clk = 1'b0, reset = 1'b0, clk4 = 1'b0, start = 1'b0;
  logic       gedaald = 1'b0, gelijk = 1'b0, error = 1'b0;
  logic [1:0] stand;
  logic       motor_aan, klaar, fout;
  int         checks = 0, failures = 0;
  typedef struct {
    string      tag;
    logic [4:0] ex;
  } exp_t;
  exp_t q[$];
  // Expected {stand, motor_aan, klaar, fout}.
  localparam logic [4:0] OFF = 5'b00_0_0_0, S1 = 5'b01_1_0_0, S2 = 5'b10_1_0_0;
  localparam logic [4:0] S3 = 5'b11_1_0_0, DONE = 5'b00_0_1_0, FLT = 5'b00_0_0_1;

  wieg_sturing dut (
    .clk(clk), .reset(reset), .clk4(clk4), .start(start), .gedaald(gedaald),
    .gelijk(gelijk), .error(error), .stand(stand), .motor_aan(motor_aan),
    .klaar(klaar), .fout(fout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic st, input logic c4, input logic gd,
                      input logic gl, input logic er, input logic [4:0] ex);
    exp_t cur;
    start = st;
    clk4 = c4;
    gedaald = gd;
    gelijk = gl;
    error = er;
    q.push_back('{tag, ex});
    @(posedge clk);
    #1;
    cur = q.pop_front();
    chk(cur.tag, {stand, motor_aan, klaar, fout}, cur.ex);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {stand, motor_aan, klaar, fout}, OFF);
    reset = 1'b1;
    step("rust_idle", 0, 0, 0, 0, 0, OFF);
    step("start", 1, 0, 0, 0, 0, S2);
    step("settle", 0, 1, 0, 1, 0, S2);
    for (int i = 0; i < 3; i++) step("gel_hold", 0, 1, 0, 1, 0, S2);
    step("gel_up", 0, 1, 0, 1, 0, S3);
    for (int i = 0; i < 4; i++) step("gel_sat", 0, 1, 0, 1, 0, S3);
    step("both_1", 0, 1, 1, 1, 0, S3);
    step("both_down", 0, 1, 1, 1, 0, S2);
    step("daal_1", 0, 1, 1, 0, 0, S2);
    step("daal_to1", 0, 1, 1, 0, 0, S1);
    step("daal_a", 0, 1, 1, 0, 0, S1);
    step("to_afbouw", 0, 1, 1, 0, 0, S1);
    step("afb_both", 0, 1, 1, 1, 0, S1);
    for (int i = 0; i < 6; i++) step("afb_cnt", 0, 1, 1, 0, 0, S1);
    step("afb_done", 0, 1, 1, 0, 0, DONE);
    step("klaar_pulse", 0, 0, 0, 0, 0, OFF);
    step("start2", 1, 0, 0, 0, 0, S2);
    step("settle2", 0, 1, 0, 0, 0, S2);
    for (int i = 0; i < 100; i++) step("no_strobe", 0, 0, 0, 1, 0, S2);
    for (int i = 0; i < 3; i++) step("gel_after", 0, 1, 0, 1, 0, S2);
    step("rose", 0, 1, 0, 0, 0, S3);
    step("start_ign", 1, 0, 0, 0, 0, S3);
    start = 1'b0;
    #2 reset = 1'b0;
    #1 chk("async_reset", {stand, motor_aan, klaar, fout}, OFF);
    @(posedge clk);
    #1;
    chk("reset_held", {stand, motor_aan, klaar, fout}, OFF);
    reset = 1'b1;
    step("rust_after", 0, 0, 0, 0, 0, OFF);
    step("start3", 1, 0, 0, 0, 0, S2);
    step("settle3", 0, 1, 0, 0, 1, S2);
    step("err_a", 0, 1, 0, 0, 1, S2);
    step("ok_b", 0, 1, 0, 1, 0, S2);
    step("err_c", 0, 1, 0, 0, 1, S2);
    step("err_d", 0, 1, 0, 0, 1, S2);
    step("err_fault", 0, 1, 0, 0, 1, FLT);
    step("fout_hold", 0, 1, 0, 0, 0, FLT);
    step("fout_clear", 1, 0, 0, 0, 0, OFF);
    step("rust_stay", 0, 0, 0, 0, 0, OFF);
    step("start4", 1, 0, 0, 0, 0, S2);
    step("settle4", 0, 1, 1, 0, 0, S2);
    step("d4_a", 0, 1, 1, 0, 0, S2);
    step("d4_to1", 0, 1, 1, 0, 0, S1);
    step("d4_b", 0, 1, 1, 0, 0, S1);
    step("d4_afb", 0, 1, 1, 0, 0, S1);
    for (int i = 0; i < 3; i++) step("afb_part", 0, 1, 1, 0, 0, S1);
    step("afb_rose", 0, 1, 0, 0, 0, S2);
    step("d5_a", 0, 1, 1, 0, 0, S2);
    step("d5_to1", 0, 1, 1, 0, 0, S1);
    step("d5_b", 0, 1, 1, 0, 0, S1);
    step("d5_afb", 0, 1, 1, 0, 0, S1);
    for (int i = 0; i < 7; i++) step("afb_fresh", 0, 1, 0, 1, 0, S1);
    step("afb_done2", 0, 1, 0, 1, 0, DONE);
    step("klaar_pulse2", 0, 0, 0, 0, 0, OFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
